// File: rtl/ef_pwm_deadtime.sv
// Complementary PWM stage with dead-time insertion and a latched fault input.
// Splits one raw PWM into high/low-side drives that never overlap.
module ef_pwm_deadtime #(
    parameter int DT_W = 8
) (
    input  logic            PCLK,
    input  logic            PRESETn,
    input  logic            en,
    input  logic            pwm_in,
    input  logic [DT_W-1:0] dead_time,
    input  logic            pwm_fault,
    input  logic            fault_clr,
    output logic            pwm_h,
    output logic            pwm_l,
    output logic            fault_latched,
    output logic            dt_active
);

    typedef enum logic [2:0] {
        S_OFF,
        S_FAULT,
        S_DEAD,
        S_H_ON,
        S_L_ON
    } state_t;

    state_t          state, state_nxt;
    logic [DT_W-1:0] cnt, cnt_nxt;
    logic            tgt, tgt_nxt;
    logic            fault_nxt;

    // NOTE: every variable gets a default before any branch, so no path through the block can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tgt_nxt   = tgt;
        fault_nxt = fault_latched;

        if (pwm_fault) begin
            state_nxt = S_FAULT;
            fault_nxt = 1'b1;
        end else if (state == S_FAULT) begin
            // Only an explicit clear leaves FAULT; en=0 alone does not.
            if (fault_clr) begin
                state_nxt = S_OFF;
                fault_nxt = 1'b0;
            end
        end else if (!en) begin
            state_nxt = S_OFF;
        end else begin
            unique case (state)
                S_OFF: begin
                    state_nxt = S_DEAD;
                    tgt_nxt   = pwm_in;
                    cnt_nxt   = dead_time;
                end
                S_DEAD: begin
                    // A pulse shorter than the dead time restarts the interval toward the new side.
                    if (pwm_in != tgt) begin
                        tgt_nxt = pwm_in;
                        cnt_nxt = dead_time;
                    end else if (cnt == '0) begin
                        state_nxt = tgt ? S_H_ON : S_L_ON;
                    end else begin
                        cnt_nxt = cnt - DT_W'(1);
                    end
                end
                S_H_ON: begin
                    if (!pwm_in) begin
                        state_nxt = S_DEAD;
                        tgt_nxt   = 1'b0;
                        cnt_nxt   = dead_time;
                    end
                end
                S_L_ON: begin
                    if (pwm_in) begin
                        state_nxt = S_DEAD;
                        tgt_nxt   = 1'b1;
                        cnt_nxt   = dead_time;
                    end
                end
                default: state_nxt = S_OFF;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state         <= S_OFF;
            cnt           <= '0;
            tgt           <= 1'b0;
            fault_latched <= 1'b0;
            pwm_h         <= 1'b0;
            pwm_l         <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            tgt           <= tgt_nxt;
            fault_latched <= fault_nxt;
            // Drives decode the next state so they switch on the same edge as the state.
            pwm_h         <= (state_nxt == S_H_ON);
            pwm_l         <= (state_nxt == S_L_ON);
        end
    end

    assign dt_active = (state == S_DEAD);

endmodule

// File: tb/tb_ef_pwm_deadtime.sv
// Directed bench for ef_pwm_deadtime: dead-time gaps, glitch restart, fault latch and async reset.
module tb_ef_pwm_deadtime;

    localparam int DT_W = 8;

    logic            PCLK;
    logic            PRESETn;
    logic            en;
    logic            pwm_in;
    logic [DT_W-1:0] dead_time;
    logic            pwm_fault;
    logic            fault_clr;
    logic            pwm_h;
    logic            pwm_l;
    logic            fault_latched;
    logic            dt_active;

    logic clk_run;
    int   checks;
    int   errors;
    int   gap;
    int   n;
    logic h_seen;

    ef_pwm_deadtime #(.DT_W(DT_W)) dut (
        .PCLK          (PCLK),
        .PRESETn       (PRESETn),
        .en            (en),
        .pwm_in        (pwm_in),
        .dead_time     (dead_time),
        .pwm_fault     (pwm_fault),
        .fault_clr     (fault_clr),
        .pwm_h         (pwm_h),
        .pwm_l         (pwm_l),
        .fault_latched (fault_latched),
        .dt_active     (dt_active)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = clk_run ? ~PCLK : 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Counts cycles with both drives low after a pwm_in change, until one side rises.
    task automatic measure_gap(output int g);
        g = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (pwm_h || pwm_l) break;
            g++;
        end
    endtask

    always @(negedge PCLK) check("no_overlap", 32'(pwm_h & pwm_l), 32'd0);

    initial begin
        checks    = 0;
        errors    = 0;
        clk_run   = 1'b1;
        PRESETn   = 1'b0;
        en        = 1'b0;
        pwm_in    = 1'b0;
        dead_time = 8'd3;
        pwm_fault = 1'b0;
        fault_clr = 1'b0;

        #3;
        check("rst_h", 32'(pwm_h), 32'd0);
        check("rst_l", 32'(pwm_l), 32'd0);
        check("rst_fault", 32'(fault_latched), 32'd0);
        check("rst_dt", 32'(dt_active), 32'd0);

        @(negedge PCLK);
        PRESETn = 1'b1;
        tick();
        check("off_idle_dt", 32'(dt_active), 32'd0);

        // Start-up: OFF -> 4 cycles DEAD -> H_ON
        en = 1'b1; pwm_in = 1'b1;
        tick();
        check("start_dead", 32'(dt_active), 32'd1);
        repeat (3) tick();
        check("start_dead_end", 32'(dt_active), 32'd1);
        check("start_h_low", 32'(pwm_h), 32'd0);
        tick();
        check("start_h_on", 32'(pwm_h), 32'd1);

        // Square wave of period 20, dead_time=3: 4-cycle gap each way
        for (int p = 0; p < 2; p++) begin
            pwm_in = 1'b0;
            measure_gap(gap);
            check("sq_gap_hl", 32'(gap), 32'd4);
            check("sq_l_on", 32'(pwm_l), 32'd1);
            repeat (5) tick();
            pwm_in = 1'b1;
            measure_gap(gap);
            check("sq_gap_lh", 32'(gap), 32'd4);
            check("sq_h_on", 32'(pwm_h), 32'd1);
            repeat (5) tick();
        end

        // dead_time=0: a single low cycle between sides
        dead_time = 8'd0;
        pwm_in = 1'b0;
        measure_gap(gap);
        check("dt0_gap_hl", 32'(gap), 32'd1);
        check("dt0_l_on", 32'(pwm_l), 32'd1);
        repeat (2) tick();
        pwm_in = 1'b1;
        measure_gap(gap);
        check("dt0_gap_lh", 32'(gap), 32'd1);
        check("dt0_h_on", 32'(pwm_h), 32'd1);

        // dead_time changed mid-interval must not stretch the running count
        dead_time = 8'd3;
        pwm_in = 1'b0;
        tick();
        check("mid_dead", 32'(dt_active), 32'd1);
        dead_time = 8'd7;
        repeat (3) tick();
        check("mid_still_dead", 32'(dt_active), 32'd1);
        tick();
        check("mid_l_on", 32'(pwm_l), 32'd1);

        // 2-cycle glitch in L_ON with dead_time=5
        dead_time = 8'd5;
        h_seen = 1'b0;
        pwm_in = 1'b1;
        tick();
        check("gl_l_off", 32'(pwm_l), 32'd0);
        check("gl_dead", 32'(dt_active), 32'd1);
        h_seen |= pwm_h;
        tick();
        h_seen |= pwm_h;
        pwm_in = 1'b0;
        tick();
        h_seen |= pwm_h;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            h_seen |= pwm_h;
            if (pwm_l) break;
        end
        check("gl_relatency", 32'(n), 32'd6);
        check("gl_no_h", 32'(h_seen), 32'd0);

        // en=0 drops to OFF; re-enable inserts a full dead interval
        en = 1'b0;
        tick();
        check("dis_l_off", 32'(pwm_l), 32'd0);
        check("dis_dt", 32'(dt_active), 32'd0);
        en = 1'b1; dead_time = 8'd3;
        tick();
        check("reen_dead", 32'(dt_active), 32'd1);
        repeat (3) tick();
        check("reen_l_low", 32'(pwm_l), 32'd0);
        tick();
        check("reen_l_on", 32'(pwm_l), 32'd1);

        // Fault pulse in H_ON
        pwm_in = 1'b1;
        measure_gap(gap);
        check("pre_fault_gap", 32'(gap), 32'd4);
        check("pre_fault_h", 32'(pwm_h), 32'd1);
        pwm_fault = 1'b1;
        tick();
        pwm_fault = 1'b0;
        check("flt_h_off", 32'(pwm_h), 32'd0);
        check("flt_latched", 32'(fault_latched), 32'd1);
        check("flt_dt", 32'(dt_active), 32'd0);
        repeat (3) tick();
        check("flt_hold_h", 32'(pwm_h), 32'd0);
        check("flt_hold_latch", 32'(fault_latched), 32'd1);
        fault_clr = 1'b1; pwm_fault = 1'b1;
        tick();
        fault_clr = 1'b0; pwm_fault = 1'b0;
        check("flt_clr_vs_fault", 32'(fault_latched), 32'd1);
        check("flt_clr_vs_fault_h", 32'(pwm_h), 32'd0);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("flt_cleared", 32'(fault_latched), 32'd0);
        check("flt_off_h", 32'(pwm_h), 32'd0);
        check("flt_off_dt", 32'(dt_active), 32'd0);
        tick();
        check("flt_resume_dead", 32'(dt_active), 32'd1);
        repeat (3) tick();
        check("flt_resume_dead_end", 32'(dt_active), 32'd1);
        check("flt_resume_h_low", 32'(pwm_h), 32'd0);
        tick();
        check("flt_resume_h", 32'(pwm_h), 32'd1);
        check("flt_resume_dt_off", 32'(dt_active), 32'd0);

        // Async reset in mid-DEAD with the clock stopped
        pwm_in = 1'b0;
        tick();
        tick();
        check("rd_dead", 32'(dt_active), 32'd1);
        clk_run = 1'b0;
        #20;
        PRESETn = 1'b0;
        #1;
        check("rd_h", 32'(pwm_h), 32'd0);
        check("rd_l", 32'(pwm_l), 32'd0);
        check("rd_dt", 32'(dt_active), 32'd0);
        check("rd_fault", 32'(fault_latched), 32'd0);
        #10;
        PRESETn = 1'b1;
        #5;
        clk_run = 1'b1;
        tick();
        check("rd_restart_dead", 32'(dt_active), 32'd1);
        repeat (3) tick();
        check("rd_restart_l_low", 32'(pwm_l), 32'd0);
        check("rd_restart_dead_end", 32'(dt_active), 32'd1);
        tick();
        check("rd_restart_l_on", 32'(pwm_l), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ef_pwm_deadtime.md
EF_PWM_DEADTIME -- requirements
Module: ef_pwm_deadtime

Interface
REQ-001 SHALL have parameter DT_W, default 8, which is the width of the dead-time count.
REQ-002 SHALL have port PCLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port PRESETn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port en, input, 1 bit: stage enable.
REQ-005 SHALL have port pwm_in, input, 1 bit: raw PWM from the TMR32 pwm0/pwm1 output, in the PCLK domain, not resynchronised.
REQ-006 SHALL have port dead_time, input, DT_W bits: dead interval in PCLK cycles, sampled on entry to DEAD.
REQ-007 SHALL have port pwm_fault, input, 1 bit: active-high external fault.
REQ-008 SHALL have port fault_clr, input, 1 bit: single-cycle request to clear the latched fault.
REQ-009 SHALL have port pwm_h, output, 1 bit: high-side drive, registered.
REQ-010 SHALL have port pwm_l, output, 1 bit: low-side drive, registered.
REQ-011 SHALL have port fault_latched, output, 1 bit: sticky fault status, registered.
REQ-012 SHALL have port dt_active, output, 1 bit: high while in the DEAD state.

Function
REQ-013 SHALL implement states OFF, FAULT, DEAD, H_ON and L_ON, plus a DT_W-bit down-counter cnt and a 1-bit target tgt.
REQ-014 Outputs SHALL be driven as follows: pwm_h=1 only in H_ON; pwm_l=1 only in L_ON; both 0 in OFF, FAULT and DEAD.
REQ-015 pwm_h and pwm_l SHALL never both be 1 in any cycle.
REQ-016 Priority per edge SHALL be, highest first: pwm_fault=1, then en=0, then normal transitions.
REQ-017 When pwm_fault=1 in any state: next state FAULT, fault_latched<=1; outputs 0 on the same edge, so latency is 1 cycle.
REQ-018 In FAULT, fault_clr=1 with pwm_fault=0 SHALL clear fault_latched and go to OFF; if fault_clr and pwm_fault are both 1, the fault wins and the latch stays 1.
REQ-019 When en=0 and not FAULT: next state OFF.
REQ-020 In OFF with en=1: go to DEAD with tgt<=pwm_in and cnt<=dead_time, so restart always inserts a full dead interval.
REQ-021 In H_ON with pwm_in=0: pwm_h falls on that edge; go to DEAD with tgt<=0 and cnt<=dead_time.
REQ-022 In L_ON with pwm_in=1: pwm_l falls on that edge; go to DEAD with tgt<=1 and cnt<=dead_time.
REQ-023 In DEAD with cnt==0: go to H_ON if tgt=1, else L_ON; otherwise cnt<=cnt-1.
REQ-024 As a result, the gap between one output falling and the other rising SHALL be exactly dead_time+... cycles as follows: dead_time=0 gives 1 cycle, dead_time=N gives N+1 cycles.
REQ-025 In DEAD, a pwm_in change away from tgt (a pulse shorter than the dead time) SHALL set tgt<=pwm_in and reload cnt<=dead_time, so the dead interval restarts.
REQ-026 A dead_time change in mid-interval SHALL NOT affect the running cnt; the new value takes effect at the next DEAD entry.
REQ-027 dt_active SHALL equal (state==DEAD).
REQ-028 fault_latched SHALL change only per REQ-017 and REQ-018.

Reset
REQ-029 While PRESETn=0: state OFF, cnt=0, tgt=0, pwm_h=0, pwm_l=0, fault_latched=0, dt_active=0; all take effect asynchronously.
REQ-030 After deassertion, the first active edge SHALL follow REQ-016 to REQ-020.
REQ-031 Reset asserted mid-DEAD or mid-FAULT SHALL discard the count and the fault latch.

Verification
REQ-032 Bench SHALL cover: en=1, dead_time=3, pwm_in square wave of period 20 -> pwm_h falls, both outputs low for exactly 4 cycles, then pwm_l rises; symmetric on the opposite edge; checker asserts pwm_h&pwm_l==0 every cycle.
REQ-033 Bench SHALL cover: dead_time=0, pwm_in toggling -> exactly 1 cycle with both outputs low between sides.
REQ-034 Bench SHALL cover: dead_time=5, a 2-cycle high glitch on pwm_in while in L_ON -> pwm_h never asserts; pwm_l reasserts 6 cycles after the glitch ends.
REQ-035 Bench SHALL cover: pwm_fault pulsed for 1 cycle while in H_ON -> next edge pwm_h=0 and fault_latched=1; outputs stay 0 until fault_clr, then a 4-cycle dead interval (dead_time=3) before resuming.
REQ-036 Bench SHALL cover: fault_clr together with pwm_fault=1 -> fault_latched stays 1.
REQ-037 Bench SHALL cover: PRESETn asserted during a DEAD count with no clock running -> all outputs 0 immediately; after release with en=1, a full dead interval precedes the first drive.
